// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencer.
package md_pkg;

    localparam int unsigned MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef logic [2:0] md_state_t;

    localparam md_state_t ST_IDLE = 3'd0;
    localparam md_state_t ST_PREP = 3'd1;
    localparam md_state_t ST_RUN  = 3'd2;
    localparam md_state_t ST_FIX  = 3'd3;
    localparam md_state_t ST_DONE = 3'd4;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// Double-width product/remainder register with the shift-add / restoring-subtract datapath.
// shamt is normally 1; a larger value aligns the product in one step when a multiply ends early.
module md_shift_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic                 is_div,
    input  logic [CNT_W-1:0]     shamt,
    input  logic [WIDTH-1:0]     load_lo,
    input  logic [WIDTH-1:0]     load_opnd,
    input  logic                 neg_prod,
    input  logic                 neg_hi,
    input  logic                 neg_lo,
    output logic [2*WIDTH-1:0]   prod
);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] wide;

    always_comb begin
        prod_d = prod_q;
        opnd_d = opnd_q;
        // Restoring divide: remainder shifted left with the next dividend bit.
        rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, opnd_q};
        diff   = WIDTH'(rem_sh - {1'b0, opnd_q});
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        wide   = (2*WIDTH)'({sum, prod_q[WIDTH-1:0]} >> shamt);

        if (load) begin
            prod_d = {{WIDTH{1'b0}}, load_lo};
            opnd_d = load_opnd;
        end else if (step && is_div) begin
            if (ge) prod_d = {diff, prod_q[WIDTH-2:0], 1'b1};
            else    prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        end else if (step) begin
            prod_d = wide;
        end else if (fix) begin
            if (neg_prod) begin
                prod_d = -prod_q;
            end else begin
                if (neg_hi) prod_d[2*WIDTH-1:WIDTH] = -prod_q[2*WIDTH-1:WIDTH];
                if (neg_lo) prod_d[WIDTH-1:0]       = -prod_q[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            opnd_q <= '0;
        end else begin
            prod_q <= prod_d;
            opnd_q <= opnd_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer: FSM, iteration counter, sign fix-up, HI/LO pulses.
// Optional MD_EARLY_OUT_EN lets multiplies leave RUN once the remaining multiplier bits are zero.
module mult_div_ctrl
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_ITER,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             HILOWrite,
    output logic             Div0
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               div0_q, neg_q, rneg_q;
    logic               accept, div0_hit, active, is_div;
    logic               load, step, fix;
    logic [CNT_W-1:0]   shamt;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;

    assign active   = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
    assign accept   = (state_q == ST_IDLE) && start && !abort;
    assign div0_hit = md_is_div(op) && (b == '0);
    assign is_div   = md_is_div(op_q);
    assign sgn_a    = md_is_signed(op_q) & a_q[WIDTH-1];
    assign sgn_b    = md_is_signed(op_q) & b_q[WIDTH-1];
    assign abs_a    = sgn_a ? -a_q : a_q;
    assign abs_b    = sgn_b ? -b_q : b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        shamt   = CNT_W'(1);
        case (state_q)
            ST_IDLE: if (accept) state_d = div0_hit ? ST_DONE : ST_PREP;
            ST_PREP: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
`ifdef MD_EARLY_OUT_EN
                // Unshifted multiplier bits above the current LSB are all zero: finish the shift now.
                if (!is_div && (((prod[WIDTH-1:0] & ({WIDTH{1'b1}} >> cnt_q)) >> 1) == '0)) begin
                    shamt   = CNT_W'(WIDTH) - cnt_q;
                    state_d = ST_FIX;
                end
`endif
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && active) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            step    = 1'b0;
            fix     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div0_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                div0_q <= div0_hit;
            end
            if (load) begin
                neg_q  <= sgn_a ^ sgn_b;
                rneg_q <= sgn_a;
            end
            if (HILOWrite) begin
                hi_q <= prod[2*WIDTH-1:WIDTH];
                lo_q <= prod[WIDTH-1:0];
            end
        end
    end

    md_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .is_div    (is_div),
        .shamt     (shamt),
        .load_lo   (is_div ? abs_a : abs_b),
        .load_opnd (is_div ? abs_b : abs_a),
        .neg_prod  (!is_div && neg_q),
        .neg_hi    (is_div && rneg_q),
        .neg_lo    (is_div && neg_q),
        .prod      (prod)
    );

    assign busy      = active;
    assign done      = (state_q == ST_DONE);
    assign HILOWrite = done && !div0_q;
    assign Div0      = done && div0_q;
    // The core register holds the final result during DONE; hi/lo registers take it at that edge.
    assign hi        = HILOWrite ? prod[2*WIDTH-1:WIDTH] : hi_q;
    assign lo        = HILOWrite ? prod[WIDTH-1:0] : lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, corner sequences, random vs model.
module tb_mult_div_ctrl;
    import md_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, hilowrite, div0;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } vec_t;

    vec_t vecs[13];

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .HILOWrite (hilowrite),
        .Div0      (div0)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic; div0 leaves HI/LO at their prior values.
    function automatic void md_model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                     input logic [31:0] phi, input logic [31:0] plo,
                                     output logic [31:0] mhi, output logic [31:0] mlo,
                                     output logic mdiv0);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        mdiv0 = 1'b0;
        mhi = phi;
        mlo = plo;
        case (mop)
            MD_MULT: begin
                p = sa * sb;
                mhi = p[63:32];
                mlo = p[31:0];
            end
            MD_MULTU: begin
                p = ua * ub;
                mhi = p[63:32];
                mlo = p[31:0];
            end
            MD_DIV: begin
                if (mb == 32'd0) mdiv0 = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    mhi = r[31:0];
                    mlo = q[31:0];
                end
            end
            default: begin
                if (mb == 32'd0) mdiv0 = 1'b1;
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    mhi = ur[31:0];
                    mlo = uq[31:0];
                end
            end
        endcase
    endfunction

    // Launch one op and follow it to completion (or, with abort_at>0, through an abort).
    task automatic run_op(input string name, input logic [1:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_div0, input int abort_at, input bit poke);
        int exp_lat, lat, busy_cnt, extra;
        bit seen, wr_any;
        logic [31:0] hi_s, lo_s, mag;
        logic wr_s, d0_s;
        exp_lat = e_div0 ? 1 : 35;
`ifdef MD_EARLY_OUT_EN
        if (!t_op[1]) begin
            mag = (t_op == MD_MULT && t_b[31]) ? -t_b : t_b;
            exp_lat = 4;
            for (int i = 0; i < 32; i++) if (mag[i]) exp_lat = 4 + i;
        end
`else
        mag = '0;
`endif
        lat = 0; busy_cnt = 0; seen = 0; wr_any = 0;
        hi_s = '0; lo_s = '0; wr_s = 0; d0_s = 0;
        @(negedge clock);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(negedge clock);
            if (n == 1) begin
                start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
            end
            if (poke && n == 5) start = 1'b1;
            else if (poke && n == 6) start = 1'b0;
            abort = (abort_at == n);
            if (hilowrite) wr_any = 1;
            if (done) begin
                seen = 1; lat = n; hi_s = hi; lo_s = lo; wr_s = hilowrite; d0_s = div0;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (abort_at != 0) begin
            check({name, " done after abort"}, 64'(seen), 64'(0));
            check({name, " write after abort"}, 64'(wr_any), 64'(0));
            check({name, " hilo kept"}, {hi, lo}, {e_hi, e_lo});
            return;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(e_div0 ? 0 : exp_lat - 1));
        check({name, " hi/lo"}, {hi_s, lo_s}, {e_hi, e_lo});
        check({name, " write/div0"}, {62'd0, wr_s, d0_s}, {62'd0, !e_div0, e_div0});
        if (poke) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({name, " pulse end"}, {61'd0, done, hilowrite, busy}, 64'd0);
        check({name, " hilo hold"}, {hi, lo}, {e_hi, e_lo});
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(negedge clock);
                if (done || busy) extra++;
            end
            check({name, " ignored start"}, 64'(extra), 64'(0));
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b, m_hi, m_lo;
        logic        m_d0;
        int          bad;

        vecs[0]  = '{"mult -3*7",   MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"multu max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{"div -7/2",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{"divu 100/7",  MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{"div 5/0",     MD_DIV,   32'd5,        32'd0,        32'd2,        32'd14,       1'b1};
        vecs[5]  = '{"div ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[6]  = '{"div 7/-2",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{"div -8/-3",   MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0};
        vecs[8]  = '{"mult min^2",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
        vecs[9]  = '{"multu 2^31*2", MD_MULTU, 32'h80000000, 32'd2,       32'd1,        32'd0,        1'b0};
        vecs[10] = '{"divu max/1",  MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[11] = '{"divu 5/0",    MD_DIVU,  32'd5,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[12] = '{"mult 3*-4",   MD_MULT,  32'd3,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0};

        repeat (3) @(negedge clock);
        check("reset flags", {60'd0, busy, done, hilowrite, div0}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].div0, 0, 0);
            if (!vecs[i].div0) begin
                last_hi = vecs[i].hi;
                last_lo = vecs[i].lo;
            end
        end

        run_op("aborted multu", MD_MULTU, 32'h12345678, 32'h9ABCDEF0, last_hi, last_lo, 1'b0, 11, 0);
        run_op("mult 3*4", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, 1);
        last_hi = 32'd0;
        last_lo = 32'd12;

        // Reset in the middle of RUN.
        @(negedge clock);
        start = 1'b1; op = MD_MULTU; a = 32'hDEADBEEF; b = 32'hF0000001;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrun reset flags", {60'd0, busy, done, hilowrite, div0}, 64'd0);
        check("midrun reset hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || hilowrite || busy) bad++;
        end
        check("no write after reset", 64'(bad), 64'd0);
        last_hi = '0;
        last_lo = '0;

`ifdef MD_EARLY_OUT_EN
        run_op("early multu 5*1", MD_MULTU, 32'd5, 32'd1, 32'd0, 32'd5, 1'b0, 0, 0);
        last_lo = 32'd5;
`endif

        for (int k = 0; k < 30; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if ($urandom_range(0, 5) == 0) r_b = 32'd0;
            else if ($urandom_range(0, 1) == 1) r_b = $urandom;
            else r_b = 32'($urandom_range(0, 300));
            md_model(r_op, r_a, r_b, last_hi, last_lo, m_hi, m_lo, m_d0);
            run_op($sformatf("rand%0d op%0d", k, r_op), r_op, r_a, r_b, m_hi, m_lo, m_d0, 0, 0);
            if (!m_d0) begin
                last_hi = m_hi;
                last_lo = m_lo;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
